// File: rtl/phold_pkg.sv
// Shared types and constants for the PHOLD event engine.
package phold_pkg;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Widest-case event record; modules size their own fields from parameters.
    typedef struct packed {
        logic [31:0] ts;
        logic [7:0]  lp_id;
    } evt_t;

    function automatic int lp_width(input int num_lp);
        return (num_lp > 1) ? $clog2(num_lp) : 1;
    endfunction

endpackage

// File: rtl/phold_evq.sv
// Sorted event queue: every step pops the head and inserts one event in a single cycle.
module phold_evq
    import phold_pkg::*;
#(
    parameter int QUEUE_DEPTH = 16,
    parameter int NUM_LP      = 8,
    parameter int TIME_W      = 14,
    localparam int LPW        = lp_width(NUM_LP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic [TIME_W-1:0] ins_ts,
    input  logic [LPW-1:0]    ins_lp,
    output logic [TIME_W-1:0] head_ts,
    output logic [LPW-1:0]    head_lp
);

    logic [QUEUE_DEPTH-1:0][TIME_W-1:0] ts_q, ts_nxt;
    logic [QUEUE_DEPTH-1:0][LPW-1:0]    lp_q, lp_nxt;
    logic [QUEUE_DEPTH-1:0]             le;

    // le[i]: surviving entry i sits ahead of the new event (ties keep older first).
    always_comb begin
        le    = '0;
        le[0] = 1'b1;
        for (int i = 1; i < QUEUE_DEPTH; i++) begin
            le[i] = (ts_q[i] <= ins_ts);
        end
    end

    for (genvar j = 0; j < QUEUE_DEPTH; j++) begin : g_slot
        if (j < QUEUE_DEPTH - 1) begin : g_mid
            assign ts_nxt[j] = le[j+1] ? ts_q[j+1] : (le[j] ? ins_ts : ts_q[j]);
            assign lp_nxt[j] = le[j+1] ? lp_q[j+1] : (le[j] ? ins_lp : lp_q[j]);
        end else begin : g_tail
            assign ts_nxt[j] = le[j] ? ins_ts : ts_q[j];
            assign lp_nxt[j] = le[j] ? ins_lp : lp_q[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                ts_q[i] <= TIME_W'(i);
                lp_q[i] <= LPW'(i % NUM_LP);
            end
        end else if (step) begin
            ts_q <= ts_nxt;
            lp_q <= lp_nxt;
        end
    end

    assign head_ts = ts_q[0];
    assign head_lp = lp_q[0];

endmodule

// File: rtl/phold_core.sv
// PHOLD engine: pops one event per clock until the head reaches END_TIME, then reports GVT.
// Optional statistics counters (evt_cnt, lp_hits) are built when PHOLD_STATS_EN is defined.
module phold_core
    import phold_pkg::*;
#(
    parameter int          NUM_LP      = 8,
    parameter int          QUEUE_DEPTH = 16,
    parameter int          TIME_W      = 14,
    parameter int          DELAY_BITS  = 4,
    parameter int          END_TIME    = 1000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         LPW         = lp_width(NUM_LP)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [TIME_W-1:0]      gvt,
    output logic                   rtn_vld,
    output logic                   dbg_state,
    output logic [LPW-1:0]         dbg_lp
`ifdef PHOLD_STATS_EN
    ,
    output logic [31:0]            evt_cnt,
    output logic [NUM_LP*16-1:0]   lp_hits
`endif
);

    localparam logic [TIME_W-1:0] END_TS = TIME_W'(END_TIME);

    state_t            state, state_nxt;
    logic              step;
    logic [15:0]       lfsr, lfsr_nxt;
    logic [TIME_W-1:0] head_ts, new_ts;
    logic [LPW-1:0]    head_lp, new_lp;
    logic [TIME_W:0]   delay, sum;

    phold_evq #(
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .NUM_LP      (NUM_LP),
        .TIME_W      (TIME_W)
    ) u_evq (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (step),
        .ins_ts  (new_ts),
        .ins_lp  (new_lp),
        .head_ts (head_ts),
        .head_lp (head_lp)
    );

    if (DELAY_BITS > 0) begin : g_dly
        assign delay = {{(TIME_W + 1 - DELAY_BITS){1'b0}}, lfsr[DELAY_BITS-1:0]};
    end else begin : g_nodly
        assign delay = '0;
    end

    // One extra bit of headroom so the increment can saturate instead of wrapping.
    assign sum      = {1'b0, head_ts} + delay + (TIME_W + 1)'(1);
    assign new_ts   = sum[TIME_W] ? '1 : sum[TIME_W-1:0];
    assign new_lp   = lfsr[15 -: LPW];
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        case (state)
            RUN: begin
                if (head_ts >= END_TS) state_nxt = DONE;
                else                   step      = 1'b1;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            lfsr    <= LFSR_SEED;
            gvt     <= '0;
            rtn_vld <= 1'b0;
            dbg_lp  <= '0;
        end else begin
            state <= state_nxt;
            if (state == RUN) begin
                gvt    <= head_ts;
                dbg_lp <= head_lp;
            end
            if (step) lfsr <= lfsr_nxt;
            if (state_nxt == DONE) rtn_vld <= 1'b1;
        end
    end

    assign dbg_state = (state == DONE);

`ifdef PHOLD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= '0;
            lp_hits <= '0;
        end else if (step) begin
            if (evt_cnt != '1) evt_cnt <= evt_cnt + 32'd1;
            for (int i = 0; i < NUM_LP; i++) begin
                if (new_lp == LPW'(i) && lp_hits[i*16 +: 16] != 16'hFFFF)
                    lp_hits[i*16 +: 16] <= lp_hits[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_phold_core.sv
// Bench for phold_core: queue-based reference model, scoreboard monitor, and reset/abort stimulus.
module tb_phold_core;

    localparam int TW     = 14;
    localparam int END_T  = 1000;
    localparam int D0_END = 10;

    typedef struct {
        int ts;
        int lp;
    } ev_t;

    logic clk;
    logic rst_n;

    logic [TW-1:0] gvt, gvt_min, gvt_d0;
    logic          vld, vld_min, vld_d0;
    logic          st, st_min, st_d0;
    logic [2:0]    lp, lp_min, lp_d0;
`ifdef PHOLD_STATS_EN
    logic [31:0]   evt_cnt, evt_cnt_min, evt_cnt_d0;
    logic [127:0]  hits, hits_min, hits_d0;
`endif

    phold_core dut (
        .clk(clk), .rst_n(rst_n), .gvt(gvt), .rtn_vld(vld), .dbg_state(st), .dbg_lp(lp)
`ifdef PHOLD_STATS_EN
        , .evt_cnt(evt_cnt), .lp_hits(hits)
`endif
    );

    phold_core #(.END_TIME(0)) dut_min (
        .clk(clk), .rst_n(rst_n), .gvt(gvt_min), .rtn_vld(vld_min), .dbg_state(st_min), .dbg_lp(lp_min)
`ifdef PHOLD_STATS_EN
        , .evt_cnt(evt_cnt_min), .lp_hits(hits_min)
`endif
    );

    phold_core #(.DELAY_BITS(0), .END_TIME(D0_END)) dut_d0 (
        .clk(clk), .rst_n(rst_n), .gvt(gvt_d0), .rtn_vld(vld_d0), .dbg_state(st_d0), .dbg_lp(lp_d0)
`ifdef PHOLD_STATS_EN
        , .evt_cnt(evt_cnt_d0), .lp_hits(hits_d0)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard bookkeeping ----------------
    int n_chk  = 0;
    int n_pass = 0;
    logic [17:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    ev_t         mq[$];
    logic [15:0] m_lfsr;
    bit          m_done;
    int          m_gvt, m_lp, m_ins, m_fin;
    int          rel_cyc;

    function automatic void model_init();
        mq.delete();
        for (int i = 0; i < 16; i++) mq.push_back('{i, i % 8});
        m_lfsr = 16'hACE1;
        m_done = 0;
        m_gvt  = 0;
        m_lp   = 0;
        m_ins  = 0;
        m_fin  = 0;
    endfunction

    function automatic void model_step();
        ev_t h, e;
        int  pos;
        bit  found;
        h     = mq.pop_front();
        m_gvt = h.ts;
        m_lp  = h.lp;
        if (h.ts >= END_T) begin
            m_done = 1;
            m_fin  = rel_cyc + 1;
        end else begin
            e.ts = h.ts + 1 + int'(m_lfsr % 16);
            if (e.ts > (1 << TW) - 1) e.ts = (1 << TW) - 1;
            e.lp = int'(m_lfsr / 8192);
            pos   = mq.size();
            found = 0;
            for (int i = 0; i < mq.size(); i++) begin
                if (!found && mq[i].ts > e.ts) begin
                    pos   = i;
                    found = 1;
                end
            end
            mq.insert(pos, e);
            m_ins++;
            if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ 16'hB400;
            else                 m_lfsr = m_lfsr / 2;
        end
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            if (!m_done) model_step();
            exp_q.push_back({m_done, 3'(m_lp), 14'(m_gvt)});
            rel_cyc = rel_cyc + 1;
        end else begin
            model_init();
            rel_cyc = 0;
        end
    end

    // DELAY_BITS=0 instance: every pop at time t inserts exactly one event at t+1.
    int d0_ts[100];
    int d0_fin;
    initial begin
        int k, cnt;
        k   = 1;
        cnt = 0;
        for (int t = 0; t < D0_END; t++) begin
            cnt = (t < 16 ? 1 : 0) + cnt;
            for (int c = 0; c < cnt; c++) begin
                d0_ts[k] = t;
                k++;
            end
        end
        d0_fin = k;
    end

    function automatic int hit_sum(input logic [127:0] h);
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'(h[i*16 +: 16]);
        return s;
    endfunction

    // ---------------- monitor ----------------
    int   d_fin;
    logic vld_prev;
    logic [TW-1:0] d0_prev;

    always @(negedge clk) begin
        logic [17:0] e;
        logic        bad;
        int          k;
        if (!rst_n) begin
            vld_prev = 1'b0;
            d0_prev  = '0;
        end else if (rel_cyc > 0) begin
            k = rel_cyc;
            if (exp_q.size() == 0) begin
                chk("exp_underflow", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("main_out", {vld, lp, gvt}, e);
                chk("main_state", st, e[17]);
            end
            bad = 1'b0;
            for (int i = 1; i < 16; i++)
                if (dut.u_evq.ts_q[i] < dut.u_evq.ts_q[0]) bad = 1'b1;
            chk("evq_order", bad, 0);
            if (vld && !vld_prev) d_fin = k;
            vld_prev = vld;

            chk("min_out", {vld_min, st_min, lp_min, gvt_min}, {1'b1, 1'b1, 3'd0, 14'd0});

            if (k <= 80) begin
                if (k < d0_fin) chk("d0_out", {vld_d0, st_d0, gvt_d0}, {1'b0, 1'b0, 14'(d0_ts[k])});
                else            chk("d0_out", {vld_d0, st_d0, gvt_d0}, {1'b1, 1'b1, 14'(D0_END)});
                chk("d0_monotonic", gvt_d0 >= d0_prev, 1);
                d0_prev = gvt_d0;
                if (k == 1) chk("d0_first_lp", lp_d0, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {vld, gvt, vld_min, gvt_min, vld_d0, gvt_d0}, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", {vld, st, lp, gvt, vld_d0, gvt_d0}, 0);
        rst_n = 1'b1;
    endtask

    task automatic run_to_done();
        int n = 0;
        d_fin = 0;
        while (vld !== 1'b1 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk("run_timeout", vld, 1);
        @(negedge clk);
        #1;
        chk("finish_cycle", d_fin, m_fin);
        chk("final_gvt_range", (gvt >= 14'd1000 && gvt <= 14'd1015) ? 1 : 0, 1);
`ifdef PHOLD_STATS_EN
        chk("evt_cnt", evt_cnt, m_ins);
        chk("lp_hits_sum", hit_sum(hits), m_ins);
        chk("d0_evt_cnt", evt_cnt_d0, d0_fin - 1);
        chk("d0_hits_sum", hit_sum(hits_d0), evt_cnt_d0);
        chk("min_evt_cnt", evt_cnt_min, 0);
`endif
        repeat (6) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        rel_cyc = 0;
        model_init();

        do_reset();
        run_to_done();

        // Abort 50 cycles in, then a clean rerun from the same seed.
        do_reset();
        repeat (50) @(posedge clk);
        do_reset();
        run_to_done();

        for (int r = 0; r < 2; r++) begin
            do_reset();
            repeat ($urandom_range(5, 600)) @(posedge clk);
            do_reset();
            run_to_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
